instr_fetch_unit: RTL

- Fetch stage between the program counter and instruction memory.
- Samples the current PC address and runs one request/ready transaction to instruction memory at a time.
- Drives the PC hold signal so the PC advances only when an instruction is accepted.
- Presents fetched instructions to decode in a one-entry output register, with flush support for branch/jump redirects.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: PC handshake, instruction memory port and decode-facing output register.
interface instr_fetch_unit_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [31:0]            pcAddress;
  logic                   pcHold;
  logic                   flush;
  logic                   decodeStall;
  logic                   memReq;
  logic [31:0]            memAddr;
  logic                   memReady;
  logic [31:0]            memData;
  logic                   instrValid;
  logic [31:0]            instrOut;
  logic [31:0]            instrPC;
  logic [STALL_CNT_W-1:0] stallCount;

  // Fetch unit side
  modport master (
    input  pcAddress, flush, decodeStall, memReady, memData,
    output pcHold, memReq, memAddr, instrValid, instrOut, instrPC, stallCount
  );

  // Environment side (PC, branch logic, memory, decode)
  modport slave (
    output pcAddress, flush, decodeStall, memReady, memData,
    input  pcHold, memReq, memAddr, instrValid, instrOut, instrPC, stallCount
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory, a one-entry output
// register towards decode, and redirect (flush) handling that drains uncancellable requests.
module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            ipc_q, ipc_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic consume;
  logic can_issue;

  assign consume   = valid_q & ~bus.decodeStall;
  assign can_issue = ~bus.flush & (~valid_q | ~bus.decodeStall);

  // Next-state and datapath update for the fetch FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (can_issue) begin
          addr_d  = bus.pcAddress;
          state_d = StWait;
        end
        if (consume) valid_d = 1'b0;
      end
      StWait: begin
        if (bus.memReady) begin
          if (!bus.flush) begin
            instr_d = bus.memData;
            ipc_d   = addr_q;
            valid_d = 1'b1;
          end
          state_d = StIdle;
        end else if (bus.flush) begin
          // The request cannot be withdrawn; swallow its response later
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.memReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Redirect wins over any response landing on the same edge
    if (bus.flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    if ((state_q != StIdle) && !bus.memReady && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  // PC moves only on an accepted response or a redirect
  assign bus.pcHold     = reset | ~(bus.flush | ((state_q == StWait) & bus.memReady));
  assign bus.memReq     = (state_q != StIdle);
  assign bus.memAddr    = addr_q;
  assign bus.instrValid = valid_q;
  assign bus.instrOut   = instr_q;
  assign bus.instrPC    = ipc_q;
  assign bus.stallCount = cnt_q;

endmodule
